// File: rtl/uart_tx_stim.sv
// uart_tx_stim: 8N1 UART transmitter with a byte FIFO, used to inject console
// input into the on-chip UART. One bit lasts 16*divisor clocks (divisor 0 acts
// as 1). Divisor is captured when a frame starts.
// Build option: define UART_TX_PARITY_EN to add a parity bit (and the
// parity_odd input) between the data bits and the stop bit.
module uart_tx_stim #(
    parameter int FIFO_AW = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] divisor,
    input  logic [7:0]  tx_data,
    input  logic        tx_wr,
`ifdef UART_TX_PARITY_EN
    input  logic        parity_odd,
`endif
    output logic        tx_full,
    output logic        tx_empty,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_overflow,
    output logic        uart_tx
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_nxt;
    logic               wr_ok;
    logic               pop;

    state_t             state;
    logic [7:0]         shift;
    logic [2:0]         bit_idx;
    logic [15:0]        div_lat;
    logic [15:0]        tick_cnt;
    logic [15:0]        tick_nxt;
    logic [3:0]         sub_cnt;
    logic [3:0]         sub_nxt;
    logic               tick;
    logic               bit_end;
`ifdef UART_TX_PARITY_EN
    logic               par;
`endif

    // Tick counter reload value: divisor 0 behaves like divisor 1.
    function automatic logic [15:0] reload(input logic [15:0] d);
        return (d == 16'd0) ? 16'd0 : d - 16'd1;
    endfunction

    // Baud arithmetic, FIFO handshakes and the next occupancy count.
    always_comb begin
        tick      = (tick_cnt == 16'd0);
        bit_end   = tick && (sub_cnt == 4'hF);
        tick_nxt  = tick ? reload(div_lat) : tick_cnt - 16'd1;
        sub_nxt   = tick ? sub_cnt + 4'd1 : sub_cnt;
        // A pop at the end of a stop bit chains frames with no idle gap.
        pop       = !tx_empty && ((state == IDLE) || ((state == STOP) && bit_end));
        wr_ok     = tx_wr && !tx_full;
        count_nxt = count;
        case ({wr_ok, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // FIFO storage; payload needs no reset.
    always_ff @(posedge wb_clk_i) begin
        if (wr_ok) mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers, count and flags. Full is registered from the next count so
    // no write can overrun the array; empty trails the count by one cycle,
    // which gives the two-edge write-to-start latency.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_full     <= 1'b0;
            tx_empty    <= 1'b1;
            tx_overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (tx_wr && tx_full) tx_overflow <= 1'b1;
            count    <= count_nxt;
            tx_full  <= (count_nxt == DEPTH_C);
            tx_empty <= (count == '0);
        end
    end

    // Frame state machine with registered line, busy and done outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            shift    <= 8'h00;
            bit_idx  <= 3'd0;
            div_lat  <= 16'd0;
            tick_cnt <= 16'd0;
            sub_cnt  <= 4'd0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                tick_cnt <= tick_nxt;
                sub_cnt  <= sub_nxt;
            end
            if (pop) begin
                shift    <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                par      <= ^mem[rd_ptr];
`endif
                div_lat  <= divisor;
                tick_cnt <= reload(divisor);
                sub_cnt  <= 4'd0;
                bit_idx  <= 3'd0;
                state    <= START;
                uart_tx  <= 1'b0;
                tx_busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        uart_tx <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            uart_tx <= shift[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state   <= PARITY;
                                uart_tx <= par ^ parity_odd;
`else
                                state   <= STOP;
                                uart_tx <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shift   <= shift >> 1;
                                uart_tx <= shift[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                            tx_busy <= 1'b0;
                        end else begin
                            // Raise done for the final clock of the stop bit.
                            tx_done <= (sub_nxt == 4'hF) && (tick_nxt == 16'd0);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        uart_tx <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed testbench for uart_tx_stim (FIFO_AW=2): reset behaviour, exact bit
// timing, FIFO full/overflow, contiguous loopback frames, divisor handling and,
// when UART_TX_PARITY_EN is defined, the parity bit.
`timescale 1ns/1ps
module tb_uart_tx_stim;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = 16 * NB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] divisor = 16'd1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_wr = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd = 1'b0;
    logic        rx_par;
`endif
    logic        tx_full, tx_empty, tx_busy, tx_done, tx_overflow, uart_tx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_q[$];

    uart_tx_stim #(.FIFO_AW(2)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .divisor    (divisor),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx_full    (tx_full),
        .tx_empty   (tx_empty),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_overflow(tx_overflow),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (tx_done === 1'b1) done_q.push_back(cyc);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_data = b;
        tx_wr   = 1'b1;
        step();
        tx_wr   = 1'b0;
    endtask

    // Expected line level c clocks after the start bit begins (divisor 1).
    function automatic logic exp_line(input logic [7:0] d, input int c);
        int k;
        k = c / 16;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return (^d) ^ parity_odd;
`endif
        return 1'b1;
    endfunction

    // Bench UART receiver: finds a start bit, samples mid-bit, checks framing.
    task automatic rx_frame(input int div, output logic [7:0] b, output int st);
        int bt;
        int n;
        bt = 16 * ((div == 0) ? 1 : div);
        b  = 8'h00;
        st = -1;
        n  = 0;
        while (uart_tx !== 1'b0 && n < 40000) begin
            step();
            n++;
        end
        if (uart_tx !== 1'b0) begin
            check_val("rx_start_timeout", 32'(uart_tx), 32'd0);
            return;
        end
        st = cyc;
        repeat (bt / 2) step();
        check_val("rx_start_bit", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (bt) step();
            b[i] = uart_tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (bt) step();
        rx_par = uart_tx;
`endif
        repeat (bt) step();
        check_val("rx_stop_bit", 32'(uart_tx), 32'd1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int p;
        int bad;
        int st[6];
        logic [7:0] rb[6];

        // Reset values
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_uart_tx", 32'(uart_tx), 32'd1);
        check_val("rst_busy", 32'(tx_busy), 32'd0);
        check_val("rst_done", 32'(tx_done), 32'd0);
        check_val("rst_ovf", 32'(tx_overflow), 32'd0);
        check_val("rst_full", 32'(tx_full), 32'd0);
        check_val("rst_empty", 32'(tx_empty), 32'd1);
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single byte 0x55 at divisor 1: latency, exact bit timing, done pulse
        base = done_q.size();
        push(8'h55);
        check_val("lat_empty_n", 32'(tx_empty), 32'd1);
        step();
        check_val("lat_empty_n1", 32'(tx_empty), 32'd0);
        check_val("lat_line_n1", 32'(uart_tx), 32'd1);
        step();
        check_val("lat_busy_n2", 32'(tx_busy), 32'd1);
        p = cyc;
        for (int c = 0; c <= FRAME; c++) begin
            check_val("b55_line", 32'(uart_tx), 32'(exp_line(8'h55, c)));
            check_val("b55_done", 32'(tx_done), 32'(c == FRAME - 1));
            if (c != FRAME) step();
        end
        check_val("b55_done_cnt", 32'(done_q.size() - base), 32'd1);
        if (done_q.size() > base) check_val("b55_done_cyc", 32'(done_q[base] - p), 32'(FRAME - 1));
        check_val("b55_busy_end", 32'(tx_busy), 32'd0);

        // Asynchronous reset mid-frame discards the FIFO
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (5) step();
        check_val("mid_line_low", 32'(uart_tx), 32'd0);
        check_val("mid_not_empty", 32'(tx_empty), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_line", 32'(uart_tx), 32'd1);
        check_val("arst_busy", 32'(tx_busy), 32'd0);
        check_val("arst_empty", 32'(tx_empty), 32'd1);
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check_val("idle_hold", 32'(bad), 32'd0);

        // Full / overflow: six consecutive writes into a 4-deep FIFO
        base = done_q.size();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    tx_data = 8'(160 + i);
                    tx_wr   = 1'b1;
                    step();
                    if (i == 3) check_val("ovf_full_3", 32'(tx_full), 32'd0);
                    if (i == 4) begin
                        check_val("ovf_full_4", 32'(tx_full), 32'd1);
                        check_val("ovf_flag_4", 32'(tx_overflow), 32'd0);
                    end
                    if (i == 5) check_val("ovf_flag_5", 32'(tx_overflow), 32'd1);
                end
                tx_wr = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) rx_frame(1, rb[i], st[i]);
            end
        join
        for (int i = 0; i < 5; i++) check_val("ovf_byte", 32'(rb[i]), 32'(160 + i));
        for (int i = 1; i < 5; i++) check_val("ovf_gap", 32'(st[i] - st[i-1]), 32'(FRAME));
        repeat (2 * FRAME) step();
        check_val("ovf_frames", 32'(done_q.size() - base), 32'd5);
        check_val("ovf_sticky", 32'(tx_overflow), 32'd1);
        check_val("ovf_idle_empty", 32'(tx_empty), 32'd1);
        check_val("ovf_idle_busy", 32'(tx_busy), 32'd0);

        // Loopback "OK\n" at divisor 80, frames must be contiguous
        divisor = 16'd80;
        base = done_q.size();
        fork
            begin
                push(8'h4F);
                push(8'h4B);
                push(8'h0A);
            end
            begin
                for (int i = 0; i < 3; i++) rx_frame(80, rb[i], st[i]);
            end
        join
        check_val("lb_byte0", 32'(rb[0]), 32'h4F);
        check_val("lb_byte1", 32'(rb[1]), 32'h4B);
        check_val("lb_byte2", 32'(rb[2]), 32'h0A);
        check_val("lb_gap1", 32'(st[1] - st[0]), 32'(FRAME * 80));
        check_val("lb_gap2", 32'(st[2] - st[1]), 32'(FRAME * 80));
        repeat (FRAME * 40 + 4) step();
        check_val("lb_frames", 32'(done_q.size() - base), 32'd3);
        if (done_q.size() >= base + 3)
            check_val("lb_total", 32'(done_q[base+2] - st[0] + 1), 32'(3 * FRAME * 80));

        // Divisor 0 behaves like divisor 1
        divisor = 16'd0;
        base = done_q.size();
        fork
            push(8'h3C);
            rx_frame(0, rb[0], st[0]);
        join
        repeat (FRAME / 2 + 4) step();
        check_val("d0_byte", 32'(rb[0]), 32'h3C);
        if (done_q.size() > base) check_val("d0_len", 32'(done_q[base] - st[0] + 1), 32'(FRAME));
        else check_val("d0_done_cnt", 32'(done_q.size() - base), 32'd1);

        // Divisor change 1 -> 2 in the middle of the first frame
        divisor = 16'd1;
        base = done_q.size();
        fork
            begin
                push(8'hA5);
                push(8'h5A);
                repeat (60) step();
                divisor = 16'd2;
            end
            begin
                rx_frame(1, rb[0], st[0]);
                rx_frame(2, rb[1], st[1]);
            end
        join
        repeat (FRAME + 4) step();
        check_val("dc_byte0", 32'(rb[0]), 32'hA5);
        check_val("dc_byte1", 32'(rb[1]), 32'h5A);
        check_val("dc_gap", 32'(st[1] - st[0]), 32'(FRAME));
        check_val("dc_frames", 32'(done_q.size() - base), 32'd2);
        if (done_q.size() >= base + 2) begin
            check_val("dc_len0", 32'(done_q[base] - st[0] + 1), 32'(FRAME));
            check_val("dc_len1", 32'(done_q[base+1] - st[1] + 1), 32'(2 * FRAME));
        end

`ifdef UART_TX_PARITY_EN
        // Parity bit for 0x07: even -> 1, odd -> 0
        divisor = 16'd1;
        parity_odd = 1'b0;
        base = done_q.size();
        fork
            push(8'h07);
            rx_frame(1, rb[0], st[0]);
        join
        repeat (FRAME / 2 + 4) step();
        check_val("par_even_byte", 32'(rb[0]), 32'h07);
        check_val("par_even_bit", 32'(rx_par), 32'd1);
        if (done_q.size() > base) check_val("par_len", 32'(done_q[base] - st[0] + 1), 32'd176);
        else check_val("par_done_cnt", 32'(done_q.size() - base), 32'd1);
        parity_odd = 1'b1;
        fork
            push(8'h07);
            rx_frame(1, rb[1], st[1]);
        join
        repeat (FRAME / 2 + 4) step();
        check_val("par_odd_byte", 32'(rb[1]), 32'h07);
        check_val("par_odd_bit", 32'(rx_par), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
